// File: rtl/wishbone_pkg.sv
// Wishbone command types shared by the 128-bit master side and the 64-bit bus side.
// Includes size/cti encodings, the splitter state type, and the hexi-access test.
package wishbone_pkg;

    typedef enum logic [2:0] {
        byt   = 3'd0,
        wyde  = 3'd1,
        tetra = 3'd2,
        octa  = 3'd3,
        hexi  = 3'd4
    } wb_size_t;

    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        FIXED   = 3'b001,
        INCR    = 3'b010,
        EOL     = 3'b111
    } wb_cti_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } wb_split_state_t;

    localparam logic [15:0] SEL_HEXI = 16'hFFFF;

    typedef struct packed {
        logic [1:0]   om;
        logic [4:0]   cmd;
        logic [1:0]   bte;
        wb_cti_t      cti;
        logic [5:0]   blen;
        wb_size_t     sz;
        logic [3:0]   cid;
        logic [7:0]   tid;
        logic [15:0]  asid;
        logic [7:0]   pl;
        logic [3:0]   pri;
        logic [3:0]   cache;
        logic         csr;
        logic [2:0]   seg;
        logic         cyc;
        logic         stb;
        logic         we;
        logic [31:0]  vadr;
        logic [31:0]  padr;
        logic [15:0]  sel;
        logic [127:0] data1;
    } wb_cmd_request128_t;

    typedef struct packed {
        logic [1:0]   om;
        logic [4:0]   cmd;
        logic [1:0]   bte;
        wb_cti_t      cti;
        logic [5:0]   blen;
        wb_size_t     sz;
        logic [3:0]   cid;
        logic [7:0]   tid;
        logic [15:0]  asid;
        logic [7:0]   pl;
        logic [3:0]   pri;
        logic [3:0]   cache;
        logic         csr;
        logic [2:0]   seg;
        logic         cyc;
        logic         stb;
        logic         we;
        logic [31:0]  vadr;
        logic [31:0]  padr;
        logic [7:0]   sel;
        logic [63:0]  data1;
    } wb_cmd_request64_t;

    typedef struct packed {
        logic [3:0]   cid;
        logic [7:0]   tid;
        logic [3:0]   pri;
        logic         stall;
        logic         next;
        logic         ack;
        logic         err;
        logic         rty;
        logic [31:0]  adr;
        logic [127:0] dat;
    } wb_cmd_response128_t;

    typedef struct packed {
        logic [3:0]   cid;
        logic [7:0]   tid;
        logic [3:0]   pri;
        logic         stall;
        logic         next;
        logic         ack;
        logic         err;
        logic         rty;
        logic [31:0]  adr;
        logic [63:0]  dat;
    } wb_cmd_response64_t;

    // A full 16-byte select is treated as hexi even when sz says otherwise.
    function automatic logic is_hexi(input wb_size_t sz, input logic [15:0] sel);
        return (sz == hexi) || (sel == SEL_HEXI);
    endfunction

endpackage

// File: rtl/wb_lane_steer128to64.sv
// Picks the 64-bit lane (select and write data) of a non-hexi access using address bit 3.
// Purely combinational, no latency, no flow control of its own.
module wb_lane_steer128to64
    import wishbone_pkg::*;
(
    input  logic         adr3_i,
    input  logic [15:0]  sel_i,
    input  logic [127:0] dat_i,
    output logic [7:0]   sel_o,
    output logic [63:0]  dat_o
);

    assign sel_o = adr3_i ? sel_i[15:8]   : sel_i[7:0];
    assign dat_o = adr3_i ? dat_i[127:64] : dat_i[63:0];

endmodule

// File: rtl/wb_split128to64.sv
// Splits 128-bit hexi Wishbone accesses into two 64-bit beats and merges the replies; one beat issue cycle.
// One transaction in flight; master sees stall outside IDLE, bus stall holds the current beat.
module wb_split128to64
    import wishbone_pkg::*;
#(
    parameter int TO_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  wb_cmd_request128_t  req128_i,
    output wb_cmd_response128_t resp128_o,
    output wb_cmd_request64_t   req64_o,
    input  wb_cmd_response64_t  resp64_i
);

    localparam int TW = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = (TO_CYCLES == 0) ? '0 : TW'(TO_CYCLES - 1);

    wb_split_state_t     state_q,  state_d;
    wb_cmd_request128_t  req_q,    req_d;
    wb_cmd_request64_t   req64_q,  req64_d;
    wb_cmd_response128_t resp_q,   resp_d;
    logic [63:0]         dat_lo_q, dat_lo_d;
    logic [TW-1:0]       to_cnt_q, to_cnt_d;
    logic                abort_q,  abort_d;

    wb_cmd_request128_t  src;
    wb_cmd_request64_t   issue;
    wb_cmd_response128_t resp_base;
    logic                second;
    logic                src_hexi;
    logic [7:0]          steer_sel;
    logic [63:0]         steer_dat;
    logic                beat_live;
    logic                got_ack;
    logic                got_err;
    logic                got_rty;
    logic                timed_out;
    logic                abort_now;

    // In IDLE the beat is built from the live request, afterwards from the captured copy.
    assign second   = (state_q != IDLE);
    assign src      = second ? req_q : req128_i;
    assign src_hexi = is_hexi(src.sz, src.sel);

    wb_lane_steer128to64 u_steer (
        .adr3_i (src.padr[3]),
        .sel_i  (src.sel),
        .dat_i  (src.data1),
        .sel_o  (steer_sel),
        .dat_o  (steer_dat)
    );

    always_comb begin
        issue       = '0;
        issue.om    = src.om;
        issue.cmd   = src.cmd;
        issue.bte   = src.bte;
        issue.blen  = src.blen;
        issue.cid   = src.cid;
        issue.tid   = src.tid;
        issue.asid  = src.asid;
        issue.pl    = src.pl;
        issue.pri   = src.pri;
        issue.cache = src.cache;
        issue.csr   = src.csr;
        issue.seg   = src.seg;
        issue.we    = src.we;
        issue.cyc   = 1'b1;
        issue.stb   = 1'b1;
        if (src_hexi) begin
            // Bit 3 cleared then +8 for the upper half is just bit 3 = beat index.
            issue.sz    = octa;
            issue.sel   = 8'hFF;
            issue.padr  = {src.padr[31:4], second, src.padr[2:0]};
            issue.vadr  = {src.vadr[31:4], second, src.vadr[2:0]};
            issue.data1 = second ? src.data1[127:64] : src.data1[63:0];
            issue.cti   = second ? EOL : INCR;
        end else begin
            issue.sz    = src.sz;
            issue.sel   = steer_sel;
            issue.padr  = src.padr;
            issue.vadr  = src.vadr;
            issue.data1 = steer_dat;
            issue.cti   = src.cti;
        end
    end

    always_comb begin
        resp_base     = '0;
        resp_base.cid = req_q.cid;
        resp_base.tid = req_q.tid;
        resp_base.pri = req_q.pri;
        resp_base.adr = req_q.padr;
    end

    // Responses during a bus stall do not complete the beat; err beats ack, rty beats ack.
    assign beat_live = req64_q.stb && !resp64_i.stall;
    assign got_err   = beat_live && resp64_i.err;
    assign got_rty   = beat_live && resp64_i.rty && !resp64_i.err;
    assign got_ack   = beat_live && resp64_i.ack && !resp64_i.err && !resp64_i.rty;
    assign timed_out = (TO_CYCLES != 0) && req64_q.stb && !got_err && !got_rty && !got_ack
                       && (to_cnt_q == TO_LAST);
    assign abort_now = abort_q || !req128_i.cyc;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        req64_d  = req64_q;
        resp_d   = resp_q;
        dat_lo_d = dat_lo_q;
        to_cnt_d = to_cnt_q;
        abort_d  = abort_q;
        case (state_q)
            IDLE: begin
                if (req128_i.cyc && req128_i.stb) begin
                    req_d    = req128_i;
                    req64_d  = issue;
                    to_cnt_d = '0;
                    abort_d  = 1'b0;
                    dat_lo_d = '0;
                    state_d  = BEAT0;
                end
            end
            BEAT0, BEAT1: begin
                if (!req128_i.cyc) begin
                    abort_d = 1'b1;
                end
                if (!req64_q.stb) begin
                    // Idle gap between the two hexi beats.
                    if (abort_now) begin
                        req64_d = '0;
                        state_d = IDLE;
                    end else begin
                        req64_d  = issue;
                        to_cnt_d = '0;
                    end
                end else if (got_err || got_rty || timed_out) begin
                    req64_d = '0;
                    if (abort_now) begin
                        state_d = IDLE;
                    end else begin
                        resp_d     = resp_base;
                        resp_d.err = got_err || timed_out;
                        resp_d.rty = got_rty;
                        state_d    = RESP;
                    end
                end else if (got_ack) begin
                    if ((state_q == BEAT0) && src_hexi && !abort_now) begin
                        dat_lo_d    = resp64_i.dat;
                        req64_d.stb = 1'b0;
                        state_d     = BEAT1;
                    end else begin
                        req64_d = '0;
                        if (abort_now) begin
                            state_d = IDLE;
                        end else begin
                            resp_d     = resp_base;
                            resp_d.ack = 1'b1;
                            resp_d.dat = src_hexi ? {resp64_i.dat, dat_lo_q}
                                                  : {2{resp64_i.dat}};
                            state_d    = RESP;
                        end
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            RESP: begin
                if (!req128_i.stb) begin
                    resp_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            req_q    <= '0;
            req64_q  <= '0;
            resp_q   <= '0;
            dat_lo_q <= '0;
            to_cnt_q <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            req64_q  <= req64_d;
            resp_q   <= resp_d;
            dat_lo_q <= dat_lo_d;
            to_cnt_q <= to_cnt_d;
            abort_q  <= abort_d;
        end
    end

    assign req64_o = req64_q;

    always_comb begin
        resp128_o       = resp_q;
        resp128_o.stall = (state_q != IDLE);
    end

    logic unused_bits;
    assign unused_bits = ^{resp64_i.cid, resp64_i.tid, resp64_i.pri, resp64_i.next,
                           resp64_i.adr, src.cyc, src.stb, resp_q.stall};

endmodule

// File: tb/tb_wb_split128to64.sv
// Directed bench for wb_split128to64 with a 4-cycle timeout; bus responses are driven by hand.
module tb_wb_split128to64;
    import wishbone_pkg::*;

    logic                clk;
    logic                rst_i;
    wb_cmd_request128_t  req128_i;
    wb_cmd_response128_t resp128_o;
    wb_cmd_request64_t   req64_o;
    wb_cmd_response64_t  resp64_i;

    int checks = 0;
    int errors = 0;

    wb_split128to64 #(.TO_CYCLES(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .req128_i  (req128_i),
        .resp128_o (resp128_o),
        .req64_o   (req64_o),
        .resp64_i  (resp64_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input wb_size_t sz, input logic we, input logic [31:0] padr,
                           input logic [15:0] sel, input logic [127:0] data1);
        req128_i       = '0;
        req128_i.cyc   = 1'b1;
        req128_i.stb   = 1'b1;
        req128_i.we    = we;
        req128_i.sz    = sz;
        req128_i.padr  = padr;
        req128_i.vadr  = padr + 32'h8000_0000;
        req128_i.sel   = sel;
        req128_i.data1 = data1;
        req128_i.cti   = CLASSIC;
        req128_i.cmd   = 5'h01;
        req128_i.cid   = 4'h3;
        req128_i.tid   = 8'h5A;
        req128_i.pri   = 4'h2;
    endtask

    task automatic drop_req();
        req128_i.cyc = 1'b0;
        req128_i.stb = 1'b0;
    endtask

    task automatic bus(input logic ack, input logic err, input logic stall, input logic [63:0] dat);
        resp64_i       = '0;
        resp64_i.ack   = ack;
        resp64_i.err   = err;
        resp64_i.stall = stall;
        resp64_i.dat   = dat;
    endtask

    initial begin
        rst_i    = 1'b1;
        req128_i = '0;
        resp64_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_req64", req64_o, '0);
        chk("rst_resp128", resp128_o, '0);
        chk("rst_state", dut.state_q, IDLE);
        rst_i = 1'b0;

        // Hexi write: two beats, low half first.
        set_req(hexi, 1'b1, 32'h1000, 16'hFFFF, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222});
        @(negedge clk);
        chk("t1_b0_stb", req64_o.stb, 1'b1);
        chk("t1_b0_padr", req64_o.padr, 32'h1000);
        chk("t1_b0_dat", req64_o.data1, 64'h2222_2222_2222_2222);
        chk("t1_b0_sel", req64_o.sel, 8'hFF);
        chk("t1_b0_cti", req64_o.cti, INCR);
        chk("t1_b0_we", req64_o.we, 1'b1);
        chk("t1_stall", resp128_o.stall, 1'b1);
        bus(1'b1, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("t1_gap_stb", req64_o.stb, 1'b0);
        chk("t1_gap_cyc", req64_o.cyc, 1'b1);
        bus(1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("t1_b1_stb", req64_o.stb, 1'b1);
        chk("t1_b1_padr", req64_o.padr, 32'h1008);
        chk("t1_b1_vadr", req64_o.vadr, 32'h8000_1008);
        chk("t1_b1_dat", req64_o.data1, 64'h1111_1111_1111_1111);
        chk("t1_b1_cti", req64_o.cti, EOL);
        bus(1'b1, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("t1_ack", resp128_o.ack, 1'b1);
        chk("t1_cyc_low", req64_o.cyc, 1'b0);
        chk("t1_adr", resp128_o.adr, 32'h1000);
        bus(1'b0, 1'b0, 1'b0, 64'h0);
        drop_req();
        @(negedge clk);
        chk("t1_ack_clr", resp128_o.ack, 1'b0);
        chk("t1_idle_stall", resp128_o.stall, 1'b0);

        // Hexi read: halves merged, ack held until stb drops.
        set_req(hexi, 1'b0, 32'h3000, 16'hFFFF, 128'h0);
        @(negedge clk);
        chk("t2_b0_padr", req64_o.padr, 32'h3000);
        chk("t2_b0_we", req64_o.we, 1'b0);
        bus(1'b1, 1'b0, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA);
        @(negedge clk);
        bus(1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("t2_b1_padr", req64_o.padr, 32'h3008);
        bus(1'b1, 1'b0, 1'b0, 64'hBBBB_BBBB_BBBB_BBBB);
        @(negedge clk);
        chk("t2_ack", resp128_o.ack, 1'b1);
        chk("t2_dat", resp128_o.dat, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
        bus(1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("t2_ack_hold", resp128_o.ack, 1'b1);
        chk("t2_dat_hold", resp128_o.dat, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
        drop_req();
        @(negedge clk);
        chk("t2_ack_clr", resp128_o.ack, 1'b0);

        // Byte write in the upper lane, with one stalled cycle first.
        set_req(byt, 1'b1, 32'h2009, 16'h0200, {64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF});
        @(negedge clk);
        chk("t3_sel", req64_o.sel, 8'h02);
        chk("t3_dat", req64_o.data1, 64'hDEAD_BEEF_CAFE_F00D);
        chk("t3_padr", req64_o.padr, 32'h2009);
        chk("t3_cti", req64_o.cti, CLASSIC);
        bus(1'b1, 1'b0, 1'b1, 64'h0);
        @(negedge clk);
        chk("t3_stall_stb", req64_o.stb, 1'b1);
        chk("t3_stall_sel", req64_o.sel, 8'h02);
        chk("t3_stall_noack", resp128_o.ack, 1'b0);
        bus(1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_AB00);
        @(negedge clk);
        chk("t3_cyc_low", req64_o.cyc, 1'b0);
        chk("t3_ack", resp128_o.ack, 1'b1);
        chk("t3_rdat", resp128_o.dat, {2{64'h0000_0000_0000_AB00}});
        chk("t3_tid", resp128_o.tid, 8'h5A);
        chk("t3_adr", resp128_o.adr, 32'h2009);
        bus(1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("t3_no_beat1", req64_o.cyc, 1'b0);
        drop_req();
        @(negedge clk);

        // Tetra read in the lower lane.
        set_req(tetra, 1'b0, 32'h4004, 16'h00F0, {64'h0, 64'h7777_6666_5555_4444});
        @(negedge clk);
        chk("t4_sel", req64_o.sel, 8'hF0);
        chk("t4_dat", req64_o.data1, 64'h7777_6666_5555_4444);
        bus(1'b1, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        chk("t4_rdat", resp128_o.dat, {2{64'h1234_5678_9ABC_DEF0}});
        bus(1'b0, 1'b0, 1'b0, 64'h0);
        drop_req();
        @(negedge clk);

        // Hexi read with err on the first beat.
        set_req(hexi, 1'b0, 32'h5000, 16'hFFFF, 128'h0);
        @(negedge clk);
        chk("t5_b0_stb", req64_o.stb, 1'b1);
        bus(1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("t5_err", resp128_o.err, 1'b1);
        chk("t5_noack", resp128_o.ack, 1'b0);
        chk("t5_dat0", resp128_o.dat, 128'h0);
        chk("t5_cyc_low", req64_o.cyc, 1'b0);
        bus(1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("t5_no_beat1", req64_o.cyc, 1'b0);
        chk("t5_err_hold", resp128_o.err, 1'b1);
        drop_req();
        @(negedge clk);
        chk("t5_err_clr", resp128_o.err, 1'b0);

        // Silent slave: err four cycles after the beat appears.
        set_req(octa, 1'b0, 32'h6000, 16'h00FF, 128'h0);
        @(negedge clk);
        chk("t6_issue", req64_o.stb, 1'b1);
        repeat (3) @(negedge clk);
        chk("t6_no_err_yet", resp128_o.err, 1'b0);
        chk("t6_still_stb", req64_o.stb, 1'b1);
        @(negedge clk);
        chk("t6_to_err", resp128_o.err, 1'b1);
        chk("t6_cyc_low", req64_o.cyc, 1'b0);
        drop_req();
        @(negedge clk);

        // Master drops cyc during beat 0 of a hexi write.
        set_req(hexi, 1'b1, 32'h7000, 16'hFFFF, {64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444});
        @(negedge clk);
        chk("t7_b0_stb", req64_o.stb, 1'b1);
        drop_req();
        bus(1'b1, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("t7_cyc_low", req64_o.cyc, 1'b0);
        chk("t7_noresp", resp128_o.ack, 1'b0);
        chk("t7_idle", resp128_o.stall, 1'b0);
        bus(1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("t7_no_beat1", req64_o.cyc, 1'b0);

        // Reset during beat 1, then a fresh octa write in the upper lane.
        set_req(hexi, 1'b1, 32'h8000, 16'hFFFF, {64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666});
        @(negedge clk);
        bus(1'b1, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        bus(1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("t8_b1_padr", req64_o.padr, 32'h8008);
        rst_i = 1'b1;
        @(negedge clk);
        chk("t8_rst_cyc", req64_o.cyc, 1'b0);
        chk("t8_rst_ack", resp128_o.ack, 1'b0);
        chk("t8_rst_state", dut.state_q, IDLE);
        rst_i = 1'b0;
        set_req(octa, 1'b1, 32'h5008, 16'hFF00, {64'hFEED_FACE_0BAD_F00D, 64'h9999_9999_9999_9999});
        @(negedge clk);
        chk("t8_new_stb", req64_o.stb, 1'b1);
        chk("t8_new_padr", req64_o.padr, 32'h5008);
        chk("t8_new_sel", req64_o.sel, 8'hFF);
        chk("t8_new_dat", req64_o.data1, 64'hFEED_FACE_0BAD_F00D);
        bus(1'b1, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("t8_new_ack", resp128_o.ack, 1'b1);
        bus(1'b0, 1'b0, 1'b0, 64'h0);
        drop_req();
        @(negedge clk);
        chk("t8_end_idle", resp128_o.stall, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
